// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage pipeline: load-use stalls, EX/MEM redirects,
// data-RAM wait freeze with timeout, and a saturating stall counter. State updates on the falling edge.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic             ID_EX_MEMRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic             EX_MEM_BEQ,
  input  logic             EX_MEM_BNE,
  input  logic             EX_MEM_Zero,
  input  logic             EX_MEM_J,
  input  logic             EX_MEM_JAL,
  input  logic             EX_MEM_JR,
  input  logic             EX_MEM_MEMRead,
  input  logic             EX_MEM_MEMWrite,
  input  logic             MemReady,
  output logic             Enable_PC,
  output logic             Enable_IF_ID,
  output logic             Enable_ID_EX,
  output logic             Enable_EX_MEM,
  output logic             Enable_MEM_WB,
  output logic             Flush_IF_ID,
  output logic             Flush_ID_EX,
  output logic             Flush_EX_MEM,
  output logic [1:0]       PCSrc,
  output logic [1:0]       CtrlState,
  output logic [CNT_W-1:0] StallCount,
  output logic             MemTimeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10,
    ST_ERROR    = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout_q;

  logic memstall, taken, loaduse, stall_inc;

  assign memstall = (EX_MEM_MEMRead | EX_MEM_MEMWrite) & ~MemReady;
  assign taken    = (EX_MEM_BEQ & EX_MEM_Zero) | (EX_MEM_BNE & ~EX_MEM_Zero) |
                    EX_MEM_J | EX_MEM_JAL | EX_MEM_JR;
  assign loaduse  = ID_EX_MEMRead & (ID_EX_Rt != 5'd0) &
                    ((ID_EX_Rt == IF_ID_Rs) | (IF_ID_UsesRt & (ID_EX_Rt == IF_ID_Rt)));
  assign stall_inc = (memstall | (loaduse & ~taken)) & (state_q != ST_ERROR);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_RUN, ST_LU_STALL: begin
        wait_d = '0;
        if (memstall)                state_d = ST_MEM_WAIT;
        else if (loaduse && !taken)  state_d = ST_LU_STALL;
        else                         state_d = ST_RUN;
      end
      ST_MEM_WAIT: begin
        if (!memstall) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = ST_ERROR;
    endcase
  end

  // Outputs: reset and ERROR freeze everything; otherwise memstall > taken > loaduse > normal.
  always_comb begin
    Enable_PC     = 1'b1;
    Enable_IF_ID  = 1'b1;
    Enable_ID_EX  = 1'b1;
    Enable_EX_MEM = 1'b1;
    Enable_MEM_WB = 1'b1;
    Flush_IF_ID   = 1'b0;
    Flush_ID_EX   = 1'b0;
    Flush_EX_MEM  = 1'b0;
    PCSrc         = 2'b00;
    if (reset || state_q == ST_ERROR || memstall) begin
      Enable_PC     = 1'b0;
      Enable_IF_ID  = 1'b0;
      Enable_ID_EX  = 1'b0;
      Enable_EX_MEM = 1'b0;
      Enable_MEM_WB = 1'b0;
    end else if (taken) begin
      Flush_IF_ID  = 1'b1;
      Flush_ID_EX  = 1'b1;
      Flush_EX_MEM = 1'b1;
      if (EX_MEM_JR)                    PCSrc = 2'b11;
      else if (EX_MEM_J || EX_MEM_JAL)  PCSrc = 2'b10;
      else                              PCSrc = 2'b01;
    end else if (loaduse) begin
      Enable_PC    = 1'b0;
      Enable_IF_ID = 1'b0;
      Flush_ID_EX  = 1'b1;
    end
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (stall_inc && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
      if (state_d == ST_ERROR) timeout_q <= 1'b1;
    end
  end

  assign CtrlState  = state_q;
  assign StallCount = cnt_q;
  assign MemTimeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4); outputs sampled on the rising edge,
// state sampled just after the falling edge.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IF_ID_Rs, IF_ID_Rt, ID_EX_Rt;
  logic       IF_ID_UsesRt, ID_EX_MEMRead;
  logic       EX_MEM_BEQ, EX_MEM_BNE, EX_MEM_Zero, EX_MEM_J, EX_MEM_JAL, EX_MEM_JR;
  logic       EX_MEM_MEMRead, EX_MEM_MEMWrite, MemReady;
  logic       Enable_PC, Enable_IF_ID, Enable_ID_EX, Enable_EX_MEM, Enable_MEM_WB;
  logic       Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM;
  logic [1:0] PCSrc, CtrlState;
  logic [3:0] StallCount;
  logic       MemTimeout;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
    .ID_EX_MEMRead(ID_EX_MEMRead), .ID_EX_Rt(ID_EX_Rt),
    .EX_MEM_BEQ(EX_MEM_BEQ), .EX_MEM_BNE(EX_MEM_BNE), .EX_MEM_Zero(EX_MEM_Zero),
    .EX_MEM_J(EX_MEM_J), .EX_MEM_JAL(EX_MEM_JAL), .EX_MEM_JR(EX_MEM_JR),
    .EX_MEM_MEMRead(EX_MEM_MEMRead), .EX_MEM_MEMWrite(EX_MEM_MEMWrite), .MemReady(MemReady),
    .Enable_PC(Enable_PC), .Enable_IF_ID(Enable_IF_ID), .Enable_ID_EX(Enable_ID_EX),
    .Enable_EX_MEM(Enable_EX_MEM), .Enable_MEM_WB(Enable_MEM_WB),
    .Flush_IF_ID(Flush_IF_ID), .Flush_ID_EX(Flush_ID_EX), .Flush_EX_MEM(Flush_EX_MEM),
    .PCSrc(PCSrc), .CtrlState(CtrlState), .StallCount(StallCount), .MemTimeout(MemTimeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [4:0] en, input logic [2:0] fl,
                           input logic [1:0] pc);
    check({tag, ".en"}, {27'd0, Enable_PC, Enable_IF_ID, Enable_ID_EX, Enable_EX_MEM, Enable_MEM_WB},
          {27'd0, en});
    check({tag, ".flush"}, {29'd0, Flush_IF_ID, Flush_ID_EX, Flush_EX_MEM}, {29'd0, fl});
    check({tag, ".pcsrc"}, {30'd0, PCSrc}, {30'd0, pc});
  endtask

  task automatic check_st(input string tag, input logic [1:0] st, input logic [3:0] cnt);
    check({tag, ".state"}, {30'd0, CtrlState}, {30'd0, st});
    check({tag, ".cnt"}, {28'd0, StallCount}, {28'd0, cnt});
  endtask

  // driver tasks
  task automatic clear_inputs();
    IF_ID_Rs = 5'd0; IF_ID_Rt = 5'd0; IF_ID_UsesRt = 1'b0;
    ID_EX_MEMRead = 1'b0; ID_EX_Rt = 5'd0;
    EX_MEM_BEQ = 1'b0; EX_MEM_BNE = 1'b0; EX_MEM_Zero = 1'b0;
    EX_MEM_J = 1'b0; EX_MEM_JAL = 1'b0; EX_MEM_JR = 1'b0;
    EX_MEM_MEMRead = 1'b0; EX_MEM_MEMWrite = 1'b0; MemReady = 1'b1;
  endtask

  task automatic set_loaduse(input logic [4:0] r);
    ID_EX_MEMRead = 1'b1; ID_EX_Rt = r; IF_ID_Rs = r;
  endtask

  task automatic to_mid();
    @(posedge clk); #1;
  endtask

  task automatic to_next();
    @(negedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    #1;
    check_out("reset", 5'b00000, 3'b000, 2'b00);
    check_st("reset", 2'b00, 4'd0);
    check("reset.timeout", {31'd0, MemTimeout}, 32'd0);
    to_mid();
    reset = 1'b0;

    // normal flow
    to_mid();  check_out("normal", 5'b11111, 3'b000, 2'b00);
    to_next(); check_st("normal", 2'b00, 4'd0);

    // load-use on rs
    set_loaduse(5'd8);
    to_mid();  check_out("lu_rs", 5'b00111, 3'b010, 2'b00);
    to_next(); check_st("lu_rs", 2'b01, 4'd1);
    clear_inputs();
    to_mid();  check_out("lu_clear", 5'b11111, 3'b000, 2'b00);
    to_next(); check_st("lu_clear", 2'b00, 4'd1);

    // register zero never stalls
    set_loaduse(5'd0);
    to_mid();  check_out("lu_r0", 5'b11111, 3'b000, 2'b00);
    to_next(); check_st("lu_r0", 2'b00, 4'd1);

    // rt match only counts when the decode instruction reads rt
    clear_inputs();
    ID_EX_MEMRead = 1'b1; ID_EX_Rt = 5'd9; IF_ID_Rt = 5'd9; IF_ID_Rs = 5'd3;
    to_mid();  check_out("lu_rt_unused", 5'b11111, 3'b000, 2'b00);
    to_next(); check_st("lu_rt_unused", 2'b00, 4'd1);
    IF_ID_UsesRt = 1'b1;
    to_mid();  check_out("lu_rt_used", 5'b00111, 3'b010, 2'b00);
    to_next(); check_st("lu_rt_used", 2'b01, 4'd2);
    clear_inputs();
    to_next(); check_st("lu_rt_back", 2'b00, 4'd2);

    // taken BNE overrides a load-use
    set_loaduse(5'd8); EX_MEM_BNE = 1'b1; EX_MEM_Zero = 1'b0;
    to_mid();  check_out("bne_lu", 5'b11111, 3'b111, 2'b01);
    to_next(); check_st("bne_lu", 2'b00, 4'd2);

    // jump select priority
    clear_inputs(); EX_MEM_JR = 1'b1; EX_MEM_J = 1'b1;
    to_mid();  check_out("jr_j", 5'b11111, 3'b111, 2'b11);
    clear_inputs(); EX_MEM_JAL = 1'b1;
    to_mid();  check_out("jal", 5'b11111, 3'b111, 2'b10);
    clear_inputs(); EX_MEM_BEQ = 1'b1; EX_MEM_Zero = 1'b1;
    to_mid();  check_out("beq_taken", 5'b11111, 3'b111, 2'b01);
    EX_MEM_Zero = 1'b0;
    to_mid();  check_out("beq_not", 5'b11111, 3'b000, 2'b00);
    to_next(); check_st("branches", 2'b00, 4'd2);

    // RAM wait: 3 freeze cycles then ready
    clear_inputs(); EX_MEM_MEMRead = 1'b1; MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_mid();
      check_out("mwait", 5'b00000, 3'b000, 2'b00);
      check("mwait.state_mid", {30'd0, CtrlState}, (i == 0) ? 32'd0 : 32'd2);
      to_next();
      check_st("mwait", 2'b10, 4'(3 + i));
    end
    MemReady = 1'b1;
    to_mid();  check_out("mready", 5'b11111, 3'b000, 2'b00);
    check("mready.state_mid", {30'd0, CtrlState}, 32'd2);
    to_next(); check_st("mready", 2'b00, 4'd5);

    // redirect held during a freeze, acted on when RAM is ready
    MemReady = 1'b0; EX_MEM_J = 1'b1;
    to_mid();  check_out("held_j_frz", 5'b00000, 3'b000, 2'b00);
    to_next(); check_st("held_j_frz", 2'b10, 4'd6);
    MemReady = 1'b1;
    to_mid();  check_out("held_j_go", 5'b11111, 3'b111, 2'b10);
    to_next(); check_st("held_j_go", 2'b00, 4'd6);

    // timeout into ERROR
    clear_inputs();
    to_mid(); reset = 1'b1; #1;
    check_st("rst_pulse", 2'b00, 4'd0);
    reset = 1'b0;
    to_next();
    EX_MEM_MEMWrite = 1'b1; MemReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      to_mid();
      check_out("tmo_frz", 5'b00000, 3'b000, 2'b00);
      to_next();
      check_st("tmo", (i < 4) ? 2'b10 : 2'b11, 4'(i + 1));
    end
    check("tmo.flag", {31'd0, MemTimeout}, 32'd1);
    clear_inputs(); set_loaduse(5'd7);
    to_mid();  check_out("error_hold", 5'b00000, 3'b000, 2'b00);
    check("error_hold.flag", {31'd0, MemTimeout}, 32'd1);
    to_next(); check_st("error_hold", 2'b11, 4'd5);
    to_mid(); reset = 1'b1; #1;
    check_st("err_rst", 2'b00, 4'd0);
    check("err_rst.flag", {31'd0, MemTimeout}, 32'd0);
    reset = 1'b0;
    clear_inputs();
    to_next(); check_st("err_rst_run", 2'b00, 4'd0);

    // reset in the middle of a RAM wait
    EX_MEM_MEMRead = 1'b1; MemReady = 1'b0;
    to_next(); to_next(); check_st("pre_rst_wait", 2'b10, 4'd2);
    to_mid(); reset = 1'b1; #1;
    check_st("rst_mid_wait", 2'b00, 4'd0);
    check_out("rst_mid_wait", 5'b00000, 3'b000, 2'b00);
    #1 reset = 1'b0;
    clear_inputs();
    to_next(); check_st("post_rst", 2'b00, 4'd0);

    // saturation of the stall counter
    set_loaduse(5'd5);
    for (int i = 0; i < 18; i++) to_next();
    check_st("saturate", 2'b01, 4'd15);
    clear_inputs();
    to_next(); check_st("saturate_hold", 2'b00, 4'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
